register_renamer: RTL and testbench

- Decode-stage renamer directly upstream of the register file.
- Maps architectural rs1/rs2/rd (x0–x31) to physical registers (0–63) and supplies each source's writeback-group tag; allocates a fresh physical rd from a free list.
- Keeps a speculative map and a retired (architectural) map; retirement returns the displaced physical register to the free list.
- Flush restores the speculative state from retired state in one cycle.

---
 rtl/register_renamer_pkg.sv | 40 ++++
 rtl/register_renamer_free_list.sv | 58 +++++
 rtl/register_renamer.sv | 124 ++++++++++++
 tb/tb_register_renamer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_renamer_pkg.sv
// Shared sizing, types and helpers for the register renamer.
// Imported by the renamer top and its free-list sub-module.
package register_renamer_pkg;

  localparam int NUM_WB_GROUPS = 2;
  localparam int WB_W =
    (NUM_WB_GROUPS > 1) ? $clog2(NUM_WB_GROUPS) : 1;
  localparam int PHYS_REGS = 64;
  localparam int PHYS_W = $clog2(PHYS_REGS);
  localparam int ARCH_REGS = 32;
  localparam int ARCH_W = $clog2(ARCH_REGS);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  localparam int RS1 = 0;
  localparam int RS2 = 1;
  localparam int REGFILE_READ_PORTS = 2;

  typedef logic [PHYS_W-1:0] phys_addr_t;
  typedef logic [ARCH_W-1:0] arch_addr_t;
  typedef logic [WB_W-1:0] wb_group_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef struct packed {
    arch_addr_t rd;
    phys_addr_t phys;
    phys_addr_t prev;
    wb_group_t  wb_group;
  } renamer_retire_t;

  // Pointers all equal means full, so occupancy is offset by the depth.
  function automatic fl_ptr_t fl_count(
    input fl_ptr_t tail,
    input fl_ptr_t head
  );
    return tail - head + fl_ptr_t'(FL_DEPTH);
  endfunction

endpackage

// File: rtl/register_renamer_free_list.sv
// Circular free list of physical registers with speculative and
// committed read heads; rollback rewinds the speculative head.
module renamer_free_list
  import register_renamer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pop_i,
  input  logic              push_i,
  input  logic [PHYS_W-1:0] push_data_i,
  input  logic              commit_i,
  input  logic              rollback_i,
  output logic [PHYS_W-1:0] head_data_o,
  output logic              not_empty_o,
  output logic [FL_PTR_W-1:0] commit_count_o
);

  phys_addr_t mem_q [FL_DEPTH];
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t commit_head_q, commit_head_d;
  fl_ptr_t spec_count;

  assign spec_count = fl_count(tail_q, spec_head_q);
  assign commit_count_o = fl_count(tail_q, commit_head_q);
  assign not_empty_o = (spec_count != '0);
  assign head_data_o = mem_q[spec_head_q[FL_IDX_W-1:0]];

  always_comb begin
    tail_d = tail_q + fl_ptr_t'(push_i);
    commit_head_d = commit_head_q + fl_ptr_t'(commit_i);
    spec_head_d = spec_head_q;
    unique case (1'b1)
      rollback_i: spec_head_d = commit_head_d;
      pop_i:      spec_head_d = spec_head_q + fl_ptr_t'(1);
      default:    ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tail_q <= '0;
      spec_head_q <= '0;
      commit_head_q <= '0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= phys_addr_t'(ARCH_REGS + i);
      end
    end else begin
      tail_q <= tail_d;
      spec_head_q <= spec_head_d;
      commit_head_q <= commit_head_d;
      if (push_i) begin
        mem_q[tail_q[FL_IDX_W-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/register_renamer.sv
// Decode-stage renamer: speculative and retired rename maps with
// writeback-group tags, backed by a rollback-capable free list.
module register_renamer
  import register_renamer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              rename_valid_i,
  output logic              rename_ready_o,
  input  logic              rename_uses_rd_i,
  input  logic [ARCH_W-1:0] rs_addr_i [REGFILE_READ_PORTS],
  input  logic [ARCH_W-1:0] rd_addr_i,
  input  logic [WB_W-1:0]   rd_wb_group_i,
  output logic [PHYS_W-1:0] phys_rs_addr_o [REGFILE_READ_PORTS],
  output logic [WB_W-1:0]   rs_wb_group_o [REGFILE_READ_PORTS],
  output logic [PHYS_W-1:0] phys_rd_addr_o,
  output logic [PHYS_W-1:0] prev_phys_rd_addr_o,
  input  logic              retire_valid_i,
  input  logic [ARCH_W-1:0] retire_rd_addr_i,
  input  logic [PHYS_W-1:0] retire_phys_rd_addr_i,
  input  logic [PHYS_W-1:0] retire_prev_phys_addr_i,
  input  logic [WB_W-1:0]   retire_wb_group_i
);

  phys_addr_t spec_map_q [ARCH_REGS];
  phys_addr_t spec_map_d [ARCH_REGS];
  phys_addr_t arch_map_q [ARCH_REGS];
  phys_addr_t arch_map_d [ARCH_REGS];
  wb_group_t  spec_grp_q [ARCH_REGS];
  wb_group_t  spec_grp_d [ARCH_REGS];
  wb_group_t  arch_grp_q [ARCH_REGS];
  wb_group_t  arch_grp_d [ARCH_REGS];

  renamer_retire_t ret;
  logic       alloc;
  logic       fl_not_empty;
  phys_addr_t fl_head;
  fl_ptr_t    fl_commit_cnt;

  assign ret = {retire_rd_addr_i, retire_phys_rd_addr_i,
                retire_prev_phys_addr_i, retire_wb_group_i};

  assign alloc = rename_valid_i & rename_uses_rd_i &
                 (rd_addr_i != '0) & ~flush_i;

  renamer_free_list u_free_list (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pop_i          (alloc),
    .push_i         (retire_valid_i),
    .push_data_i    (ret.prev),
    .commit_i       (retire_valid_i),
    .rollback_i     (flush_i),
    .head_data_o    (fl_head),
    .not_empty_o    (fl_not_empty),
    .commit_count_o (fl_commit_cnt)
  );

  assign rename_ready_o = fl_not_empty;
  assign phys_rd_addr_o = alloc ? fl_head : '0;
  assign prev_phys_rd_addr_o =
    (rd_addr_i == '0) ? '0 : spec_map_q[rd_addr_i];

  // x0 is hardwired: phys 0, group 0, whatever the tables hold.
  always_comb begin
    for (int p = 0; p < REGFILE_READ_PORTS; p++) begin
      phys_rs_addr_o[p] = '0;
      rs_wb_group_o[p] = '0;
      if (rs_addr_i[p] != '0) begin
        phys_rs_addr_o[p] = spec_map_q[rs_addr_i[p]];
        rs_wb_group_o[p] = spec_grp_q[rs_addr_i[p]];
      end
    end
  end

  // Flush copies the arch tables including this cycle's retire write.
  always_comb begin
    arch_map_d = arch_map_q;
    arch_grp_d = arch_grp_q;
    if (retire_valid_i) begin
      arch_map_d[ret.rd] = ret.phys;
      arch_grp_d[ret.rd] = ret.wb_group;
    end
    spec_map_d = spec_map_q;
    spec_grp_d = spec_grp_q;
    if (flush_i) begin
      spec_map_d = arch_map_d;
      spec_grp_d = arch_grp_d;
    end else if (alloc) begin
      spec_map_d[rd_addr_i] = fl_head;
      spec_grp_d[rd_addr_i] = rd_wb_group_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_q[i] <= phys_addr_t'(i);
        arch_map_q[i] <= phys_addr_t'(i);
        spec_grp_q[i] <= '0;
        arch_grp_q[i] <= '0;
      end
    end else begin
      spec_map_q <= spec_map_d;
      arch_map_q <= arch_map_d;
      spec_grp_q <= spec_grp_d;
      arch_grp_q <= arch_grp_d;
    end
  end

`ifndef SYNTHESIS
  a_alloc_needs_ready: assert property (
    @(posedge clk_i) disable iff (rst_i)
    alloc |-> rename_ready_o);
  a_prev_not_zero: assert property (
    @(posedge clk_i) disable iff (rst_i)
    retire_valid_i |-> (ret.prev != '0));
  a_commit_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    fl_commit_cnt <= fl_ptr_t'(FL_DEPTH));
`endif

endmodule

// File: tb/tb_register_renamer.sv
// Directed and randomized checks of register_renamer against a
// queue-based model of the free list and rename maps.
module tb_register_renamer;
  import register_renamer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       rename_valid;
  logic       rename_ready;
  logic       rename_uses_rd;
  logic [4:0] rs_addr [2];
  logic [4:0] rd_addr;
  logic       rd_wb_group;
  logic [5:0] phys_rs_addr [2];
  logic       rs_wb_group [2];
  logic [5:0] phys_rd_addr;
  logic [5:0] prev_phys_rd_addr;
  logic       retire_valid;
  logic [4:0] retire_rd_addr;
  logic [5:0] retire_phys_rd_addr;
  logic [5:0] retire_prev_phys_addr;
  logic       retire_wb_group;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_renamer dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .flush_i                 (flush),
    .rename_valid_i          (rename_valid),
    .rename_ready_o          (rename_ready),
    .rename_uses_rd_i        (rename_uses_rd),
    .rs_addr_i               (rs_addr),
    .rd_addr_i               (rd_addr),
    .rd_wb_group_i           (rd_wb_group),
    .phys_rs_addr_o          (phys_rs_addr),
    .rs_wb_group_o           (rs_wb_group),
    .phys_rd_addr_o          (phys_rd_addr),
    .prev_phys_rd_addr_o     (prev_phys_rd_addr),
    .retire_valid_i          (retire_valid),
    .retire_rd_addr_i        (retire_rd_addr),
    .retire_phys_rd_addr_i   (retire_phys_rd_addr),
    .retire_prev_phys_addr_i (retire_prev_phys_addr),
    .retire_wb_group_i       (retire_wb_group)
  );

  // Reference model: maps as plain arrays, the free list as a queue
  // from the oldest uncommitted entry to the tail, and the in-flight
  // (allocated, not retired) renames in program order.
  typedef struct {
    int rd;
    int phys;
    int prev;
    int grp;
  } inflight_t;

  int sm [32];
  int am [32];
  int sg [32];
  int ag [32];
  int freeq [$];
  inflight_t infl [$];

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      sm[i] = i;
      am[i] = i;
      sg[i] = 0;
      ag[i] = 0;
    end
    freeq.delete();
    for (int i = 0; i < 32; i++) freeq.push_back(32 + i);
    infl.delete();
  endfunction

  task automatic idle();
    flush = 1'b0;
    rename_valid = 1'b0;
    rename_uses_rd = 1'b0;
    rd_addr = '0;
    rd_wb_group = 1'b0;
    rs_addr[0] = '0;
    rs_addr[1] = '0;
    retire_valid = 1'b0;
    retire_rd_addr = '0;
    retire_phys_rd_addr = '0;
    retire_prev_phys_addr = '0;
    retire_wb_group = 1'b0;
  endtask

  task automatic ren(input logic [4:0] rd, input logic g);
    rename_valid = 1'b1;
    rename_uses_rd = 1'b1;
    rd_addr = rd;
    rd_wb_group = g;
  endtask

  task automatic ret(input logic [4:0] rd, input logic [5:0] p,
                     input logic [5:0] pv, input logic g);
    retire_valid = 1'b1;
    retire_rd_addr = rd;
    retire_phys_rd_addr = p;
    retire_prev_phys_addr = pv;
    retire_wb_group = g;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); idle();
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd7;
    #1;
    n_cmp++; if (phys_rs_addr[0] !== 6'd5) begin n_err++;
      $display("FAIL reset_rs1 got %0d exp 5", phys_rs_addr[0]); end
    n_cmp++; if (phys_rs_addr[1] !== 6'd7) begin n_err++;
      $display("FAIL reset_rs2 got %0d exp 7", phys_rs_addr[1]); end
    n_cmp++; if (rs_wb_group[0] !== 1'b0) begin n_err++;
      $display("FAIL reset_grp1 got %0d exp 0", rs_wb_group[0]); end
    n_cmp++; if (rs_wb_group[1] !== 1'b0) begin n_err++;
      $display("FAIL reset_grp2 got %0d exp 0", rs_wb_group[1]); end
    n_cmp++; if (rename_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready got %0d exp 1", rename_ready); end
    n_cmp++; if (phys_rd_addr !== 6'd0) begin n_err++;
      $display("FAIL reset_phys_rd got %0d exp 0", phys_rd_addr); end
  endtask

  task automatic test_rename();
    do_reset();
    @(negedge clk); idle();
    ren(5'd3, 1'b1); rs_addr[0] = 5'd3;
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd32) begin n_err++;
      $display("FAIL ren_phys_rd got %0d exp 32", phys_rd_addr); end
    n_cmp++; if (prev_phys_rd_addr !== 6'd3) begin n_err++;
      $display("FAIL ren_prev got %0d exp 3", prev_phys_rd_addr); end
    n_cmp++; if (phys_rs_addr[0] !== 6'd3) begin n_err++;
      $display("FAIL ren_same_rs got %0d exp 3", phys_rs_addr[0]); end
    @(negedge clk); idle();
    rs_addr[0] = 5'd3;
    #1;
    n_cmp++; if (phys_rs_addr[0] !== 6'd32) begin n_err++;
      $display("FAIL ren_next_rs got %0d exp 32", phys_rs_addr[0]); end
    n_cmp++; if (rs_wb_group[0] !== 1'b1) begin n_err++;
      $display("FAIL ren_next_grp got %0d exp 1", rs_wb_group[0]); end
    @(negedge clk); idle();
    ren(5'd0, 1'b1);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd0) begin n_err++;
      $display("FAIL ren_x0 got %0d exp 0", phys_rd_addr); end
    @(negedge clk); idle();
    ren(5'd9, 1'b0);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd33) begin n_err++;
      $display("FAIL ren_after_x0 got %0d exp 33", phys_rd_addr); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); idle();
      ren(5'd1, 1'b0);
      #1;
      n_cmp++; if (phys_rd_addr !== 6'(32 + i)) begin n_err++;
        $display("FAIL exh_alloc[%0d] got %0d exp %0d",
                 i, phys_rd_addr, 32 + i); end
    end
    @(negedge clk); idle();
    ret(5'd1, 6'd32, 6'd1, 1'b0);
    #1;
    n_cmp++; if (rename_ready !== 1'b0) begin n_err++;
      $display("FAIL exh_empty got %0d exp 0", rename_ready); end
    @(negedge clk); idle();
    ren(5'd2, 1'b0);
    #1;
    n_cmp++; if (rename_ready !== 1'b1) begin n_err++;
      $display("FAIL exh_ready got %0d exp 1", rename_ready); end
    n_cmp++; if (phys_rd_addr !== 6'd1) begin n_err++;
      $display("FAIL exh_reuse got %0d exp 1", phys_rd_addr); end
  endtask

  task automatic test_flush_rollback();
    do_reset();
    @(negedge clk); idle();
    ren(5'd4, 1'b0);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd32) begin n_err++;
      $display("FAIL fr_a1 got %0d exp 32", phys_rd_addr); end
    @(negedge clk); idle();
    ren(5'd4, 1'b1);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd33) begin n_err++;
      $display("FAIL fr_a2 got %0d exp 33", phys_rd_addr); end
    n_cmp++; if (prev_phys_rd_addr !== 6'd32) begin n_err++;
      $display("FAIL fr_prev got %0d exp 32", prev_phys_rd_addr); end
    @(negedge clk); idle();
    ret(5'd4, 6'd32, 6'd4, 1'b0);
    @(negedge clk); idle();
    flush = 1'b1;
    @(negedge clk); idle();
    rs_addr[0] = 5'd4;
    ren(5'd5, 1'b0);
    #1;
    n_cmp++; if (phys_rs_addr[0] !== 6'd32) begin n_err++;
      $display("FAIL fr_rs got %0d exp 32", phys_rs_addr[0]); end
    n_cmp++; if (rs_wb_group[0] !== 1'b0) begin n_err++;
      $display("FAIL fr_grp got %0d exp 0", rs_wb_group[0]); end
    n_cmp++; if (phys_rd_addr !== 6'd33) begin n_err++;
      $display("FAIL fr_reuse got %0d exp 33", phys_rd_addr); end
  endtask

  task automatic test_retire_flush();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      ren(5'd2, 1'b0);
    end
    @(negedge clk); idle();
    ren(5'd6, 1'b1);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd40) begin n_err++;
      $display("FAIL rf_x6 got %0d exp 40", phys_rd_addr); end
    @(negedge clk); idle();
    ren(5'd3, 1'b0);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd41) begin n_err++;
      $display("FAIL rf_x3 got %0d exp 41", phys_rd_addr); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      ret(5'd2, 6'(32 + i), (i == 0) ? 6'd2 : 6'(31 + i), 1'b0);
    end
    @(negedge clk); idle();
    ret(5'd6, 6'd40, 6'd6, 1'b1);
    flush = 1'b1;
    ren(5'd7, 1'b0);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd0) begin n_err++;
      $display("FAIL rf_no_alloc got %0d exp 0", phys_rd_addr); end
    @(negedge clk); idle();
    rs_addr[0] = 5'd6; rs_addr[1] = 5'd3;
    ren(5'd8, 1'b0);
    #1;
    n_cmp++; if (phys_rs_addr[0] !== 6'd40) begin n_err++;
      $display("FAIL rf_x6_rs got %0d exp 40", phys_rs_addr[0]); end
    n_cmp++; if (rs_wb_group[0] !== 1'b1) begin n_err++;
      $display("FAIL rf_x6_grp got %0d exp 1", rs_wb_group[0]); end
    n_cmp++; if (phys_rs_addr[1] !== 6'd3) begin n_err++;
      $display("FAIL rf_x3_rs got %0d exp 3", phys_rs_addr[1]); end
    n_cmp++; if (phys_rd_addr !== 6'd41) begin n_err++;
      $display("FAIL rf_head got %0d exp 41", phys_rd_addr); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] last_rd;
    do_reset();
    last_rd = 5'd17;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle();
      if (i > 0) last_rd = 5'($urandom_range(1, 31));
      ren(last_rd, 1'($urandom_range(0, 1)));
      #1;
      n_cmp++; if (phys_rd_addr !== 6'(32 + i)) begin n_err++;
        $display("FAIL mid_alloc[%0d] got %0d exp %0d",
                 i, phys_rd_addr, 32 + i); end
    end
    @(negedge clk); idle();
    #1 rst = 1'b1;
    rs_addr[0] = 5'd17; rs_addr[1] = last_rd;
    #1;
    n_cmp++; if (phys_rs_addr[0] !== 6'd17) begin n_err++;
      $display("FAIL mid_rs1 got %0d exp 17", phys_rs_addr[0]); end
    n_cmp++; if (phys_rs_addr[1] !== 6'(last_rd)) begin n_err++;
      $display("FAIL mid_rs2 got %0d exp %0d",
               phys_rs_addr[1], last_rd); end
    n_cmp++; if (rename_ready !== 1'b1) begin n_err++;
      $display("FAIL mid_ready got %0d exp 1", rename_ready); end
    #1 rst = 1'b0;
    m_reset();
    @(negedge clk); idle();
    ren(5'd5, 1'b0);
    #1;
    n_cmp++; if (phys_rd_addr !== 6'd32) begin n_err++;
      $display("FAIL mid_next got %0d exp 32", phys_rd_addr); end
  endtask

  task automatic test_random();
    inflight_t r;
    logic alloc;
    logic e_ready;
    logic [5:0] e_rs0, e_rs1, e_rd, e_prev;
    logic e_g0, e_g1;
    logic [26:0] exp_v, got_v;
    int ret_pct, flush_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); idle();
      ret_pct = ((c / 300) % 2 == 1) ? 15 : 70;
      flush_pct = ((c / 300) % 2 == 1) ? 1 : 4;
      flush = ($urandom_range(0, 99) < flush_pct);
      rename_valid = ($urandom_range(0, 3) != 0);
      rename_uses_rd = ($urandom_range(0, 5) != 0);
      rd_addr = 5'($urandom_range(0, 31));
      rd_wb_group = 1'($urandom_range(0, 1));
      rs_addr[0] = 5'($urandom_range(0, 31));
      rs_addr[1] = 5'($urandom_range(0, 31));
      e_ready = (freeq.size() > infl.size());
      alloc = rename_valid && rename_uses_rd &&
              rd_addr != 0 && !flush;
      if (alloc && !e_ready) begin
        rename_valid = 1'b0;
        alloc = 1'b0;
      end
      if (infl.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
        r = infl[0];
        ret(5'(r.rd), 6'(r.phys), 6'(r.prev), 1'(r.grp));
      end
      e_rd = alloc ? 6'(freeq[infl.size()]) : 6'd0;
      e_prev = (rd_addr == 0) ? 6'd0 : 6'(sm[rd_addr]);
      e_rs0 = (rs_addr[0] == 0) ? 6'd0 : 6'(sm[rs_addr[0]]);
      e_rs1 = (rs_addr[1] == 0) ? 6'd0 : 6'(sm[rs_addr[1]]);
      e_g0 = (rs_addr[0] == 0) ? 1'b0 : 1'(sg[rs_addr[0]]);
      e_g1 = (rs_addr[1] == 0) ? 1'b0 : 1'(sg[rs_addr[1]]);
      exp_v = {e_rs0, e_rs1, e_g0, e_g1, e_rd, e_prev, e_ready};
      #1;
      got_v = {phys_rs_addr[0], phys_rs_addr[1], rs_wb_group[0],
               rs_wb_group[1], phys_rd_addr, prev_phys_rd_addr,
               rename_ready};
      n_cmp++; if (got_v !== exp_v) begin n_err++;
        $display("FAIL rand[%0d] got %h exp %h", c, got_v, exp_v); end
      if (retire_valid) begin
        r = infl.pop_front();
        am[r.rd] = r.phys;
        ag[r.rd] = r.grp;
        void'(freeq.pop_front());
        freeq.push_back(r.prev);
      end
      if (flush) begin
        sm = am;
        sg = ag;
        infl.delete();
      end else if (alloc) begin
        r.rd = int'(rd_addr);
        r.phys = int'(e_rd);
        r.prev = int'(e_prev);
        r.grp = int'(rd_wb_group);
        infl.push_back(r);
        sm[rd_addr] = int'(e_rd);
        sg[rd_addr] = int'(rd_wb_group);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_rename();
    test_exhaust();
    test_flush_rollback();
    test_retire_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
